// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - request/response front end for a finish-flag latency RAM; optional access timeout via MEMCTRL_TIMEOUT_EN
module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_finish
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FIN = 2'd1,
        DONE     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              mem_en_nx, mem_we_nx, resp_valid_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx, resp_rdata_nx;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt;
    logic             resp_err_nx;
`endif

    // Reset forces IDLE, but the controller cannot take a request while held in reset.
    assign req_ready = (state == IDLE) && !rst;

    // Next-state and next-output logic; the RAM-side fields only change when accepting in IDLE.
    always_comb begin
        state_nx      = state;
        mem_en_nx     = mem_en;
        mem_we_nx     = mem_we;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        resp_rdata_nx = resp_rdata;
        resp_valid_nx = 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
        resp_err_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                mem_en_nx = 1'b0;
                if (req_valid) begin
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = req_we;
                    mem_addr_nx  = req_addr;
                    mem_wdata_nx = req_wdata;
                    state_nx     = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (mem_finish) begin
                    if (!mem_we) begin
                        resp_rdata_nx = mem_rdata;
                    end
                    mem_en_nx     = 1'b0;
                    resp_valid_nx = 1'b1;
                    state_nx      = DONE;
                end
`ifdef MEMCTRL_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    mem_en_nx     = 1'b0;
                    resp_valid_nx = 1'b1;
                    resp_err_nx   = 1'b1;
                    state_nx      = RELEASE;
                end
`endif
            end
            DONE: begin
                mem_en_nx = 1'b0;
                state_nx  = RELEASE;
            end
            RELEASE: begin
                mem_en_nx = 1'b0;
                if (!mem_finish) begin
                    state_nx = IDLE;
                end
`ifdef MEMCTRL_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                end
`endif
            end
            default: begin
                mem_en_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops mem_en and any pending response at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            mem_en     <= mem_en_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            resp_rdata <= resp_rdata_nx;
            resp_valid <= resp_valid_nx;
        end
    end

`ifdef MEMCTRL_TIMEOUT_EN
    // Error flag travels with resp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else begin
            resp_err <= resp_err_nx;
        end
    end

    // Cycles spent in the current WAIT_FIN or RELEASE visit; any state change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= '0;
        end else if (state == WAIT_FIN || state == RELEASE) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl with RAM responder and reference memory
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_finish;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_finish(mem_finish)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // RAM behaviour knobs and storage
    int          fin_delay = 4;
    int          fin_hold  = 0;
    int          en_cnt    = 0;
    int          rel_cnt   = 0;
    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_rdata;

    // Monitor state
    int   cyc         = 0;
    logic prev_en     = 1'b0;
    int   en_rises    = 0;
    int   en_rise_cyc = 0;
    int   en_cur      = 0;
    int   last_en_len = 0;
    int   stale_viol  = 0;
    int   resp_n      = 0;
    logic        resp_err_q [$];
    logic [31:0] resp_rd_q  [$];
    int          resp_cyc_q [$];

    // Observe outputs, then act as the RAM, once per falling edge
    initial begin
        mem_finish = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_en && !prev_en) begin
                en_rises++;
                en_rise_cyc = cyc;
                if (mem_finish) stale_viol++;
            end
            if (mem_en) en_cur++;
            if (!mem_en && prev_en) last_en_len = en_cur;
            if (!mem_en) en_cur = 0;
            prev_en = mem_en;
            if (resp_valid) begin
                resp_n++;
                resp_err_q.push_back(resp_err);
                resp_rd_q.push_back(resp_rdata);
                resp_cyc_q.push_back(cyc);
            end
            if (rst) begin
                mem_finish = 1'b0;
                en_cnt = 0;
                rel_cnt = 0;
            end else if (mem_en && !mem_finish) begin
                en_cnt++;
                if (en_cnt >= fin_delay) begin
                    if (mem_we) ram[mem_addr] = mem_wdata;
                    else mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
                    mem_finish = 1'b1;
                    en_cnt = 0;
                end
            end else if (!mem_en && mem_finish) begin
                rel_cnt++;
                if (rel_cnt >= fin_hold) begin
                    mem_finish = 1'b0;
                    mem_rdata  = $urandom;
                    rel_cnt = 0;
                end
            end else if (!mem_en) begin
                en_cnt = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Issue one request and wait for its response; got=0 when a bound expired
    task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input int dly, input int hold,
                             output logic got, output logic err, output logic [31:0] rd,
                             output int en_len);
        int n0, k;
        got = 1'b0; err = 1'b0; rd = 32'h0; en_len = 0;
        fin_delay = dly;
        fin_hold  = hold;
        k = 0;
        while (!req_ready && k < 100) begin tick(); k++; end
        if (!req_ready) return;
        n0 = resp_n;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (resp_n == n0 && k < 300) begin tick(); k++; end
        if (resp_n == n0) return;
        got = 1'b1;
        err = resp_err_q[$];
        rd  = resp_rd_q[$];
        en_len = last_en_len;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_in_rst: got %b want 0", req_ready); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin failures++; $display("FAIL reset_mem_fields: got %b/%h/%h want 0", mem_we, mem_addr, mem_wdata); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready_idle: got %b want 1", req_ready); end
        exp_rdata = 32'h0;
    endtask

    task automatic test_write();
        logic got, err; logic [31:0] rd; int len, n0;
        n0 = resp_n;
        do_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16, 0, got, err, rd, len);
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL write_resp: got %b want 1", got); end
        checks++; if (len != 16) begin failures++; $display("FAIL write_en_len: got %0d want 16", len); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h10) begin failures++; $display("FAIL write_mem_fields: got we=%b addr=%h want 1/10", mem_we, mem_addr); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL write_err: got %b want 0", err); end
        checks++; if (rd !== exp_rdata) begin failures++; $display("FAIL write_rdata_kept: got %h want %h", rd, exp_rdata); end
        tick(); tick();
        checks++; if (resp_n - n0 != 1) begin failures++; $display("FAIL write_pulses: got %0d want 1", resp_n - n0); end
    endtask

    task automatic test_read();
        logic got, err; logic [31:0] rd; int len;
        do_access(1'b0, 32'h0000_0010, $urandom, $urandom_range(1, 8), 0, got, err, rd, len);
        exp_rdata = ref_read(32'h10);
        checks++; if (got !== 1'b1 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata: got %b/%h want 1/deadbeef", got, rd); end
        repeat (5) tick();
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata_held: got %h want deadbeef", resp_rdata); end
    endtask

    task automatic test_back_to_back();
        int r0, n0, sv0, k;
        logic [31:0] a, w, first_exp;
        a = 32'h200; w = $urandom;
        fin_delay = 4; fin_hold = 8;
        k = 0;
        while (!req_ready && k < 100) begin tick(); k++; end
        r0 = en_rises; n0 = resp_n; sv0 = stale_viol; first_exp = exp_rdata;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = w;
        ref_mem[a] = w;
        k = 0;
        while (en_rises == r0 && k < 100) begin tick(); k++; end
        req_we = 1'b0; req_wdata = $urandom;
        k = 0;
        while (en_rises < r0 + 2 && k < 200) begin tick(); k++; end
        req_valid = 1'b0;
        k = 0;
        while (resp_n < n0 + 2 && k < 200) begin tick(); k++; end
        repeat (12) tick();
        exp_rdata = ref_read(a);
        checks++; if (resp_n - n0 != 2) begin failures++; $display("FAIL b2b_pulses: got %0d want 2", resp_n - n0); end
        checks++; if (en_rises - r0 != 2) begin failures++; $display("FAIL b2b_en_rises: got %0d want 2", en_rises - r0); end
        checks++; if (stale_viol != sv0) begin failures++; $display("FAIL b2b_stale_finish: got %0d want %0d", stale_viol, sv0); end
        if (resp_n - n0 == 2) begin
            checks++; if (resp_rd_q[n0] !== first_exp) begin failures++; $display("FAIL b2b_write_rdata: got %h want %h", resp_rd_q[n0], first_exp); end
            checks++; if (resp_rd_q[n0+1] !== w) begin failures++; $display("FAIL b2b_read_rdata: got %h want %h", resp_rd_q[n0+1], w); end
        end
    endtask

    task automatic test_busy_ignore();
        int r0, n0, k;
        logic [31:0] a;
        a = 32'h300 + $urandom_range(0, 15);
        fin_delay = 12; fin_hold = 0;
        k = 0;
        while (!req_ready && k < 100) begin tick(); k++; end
        r0 = en_rises; n0 = resp_n;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        for (int i = 0; i < 8; i++) begin
            req_valid = $urandom_range(0, 1);
            req_we    = $urandom_range(0, 1);
            req_addr  = $urandom;
            tick();
            checks++; if (mem_addr !== a || mem_we !== 1'b0 || mem_en !== 1'b1) begin failures++; $display("FAIL busy_latched[%0d]: got addr=%h we=%b en=%b want %h/0/1", i, mem_addr, mem_we, mem_en, a); end
        end
        req_valid = 1'b0;
        k = 0;
        while (resp_n == n0 && k < 100) begin tick(); k++; end
        repeat (4) tick();
        exp_rdata = ref_read(a);
        checks++; if (en_rises - r0 != 1) begin failures++; $display("FAIL busy_en_rises: got %0d want 1", en_rises - r0); end
        checks++; if (resp_rdata !== exp_rdata) begin failures++; $display("FAIL busy_rdata: got %h want %h", resp_rdata, exp_rdata); end
    endtask

    task automatic test_reset_mid();
        int n0, k; logic got, err; logic [31:0] rd; int len;
        fin_delay = 1000;
        k = 0;
        while (!req_ready && k < 100) begin tick(); k++; end
        n0 = resp_n;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL rstmid_busy: got mem_en=%b want 1", mem_en); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_en, req_ready, resp_valid} !== 3'b000) begin failures++; $display("FAIL rstmid_async: got en/ready/valid=%b want 000", {mem_en, req_ready, resp_valid}); end
        tick(); tick();
        rst = 1'b0;
        exp_rdata = 32'h0;
        tick();
        checks++; if (resp_n != n0) begin failures++; $display("FAIL rstmid_no_resp: got %0d pulses want 0", resp_n - n0); end
        do_access(1'b0, 32'h10, 32'h0, 3, 1, got, err, rd, len);
        exp_rdata = ref_read(32'h10);
        checks++; if (got !== 1'b1 || rd !== exp_rdata || err !== 1'b0) begin failures++; $display("FAIL rstmid_after: got %b/%h/%b want 1/%h/0", got, rd, err, exp_rdata); end
    endtask

    task automatic test_random();
        logic got, err; logic [31:0] rd, a, w; logic we; int len, dly;
        for (int i = 0; i < 40; i++) begin
            we  = $urandom_range(0, 1);
            a   = 32'h100 + $urandom_range(0, 7);
            w   = $urandom;
            dly = $urandom_range(1, 10);
            do_access(we, a, w, dly, $urandom_range(0, 5), got, err, rd, len);
            if (we) ref_mem[a] = w;
            else exp_rdata = ref_read(a);
            checks++; if (got !== 1'b1 || rd !== exp_rdata || err !== 1'b0) begin failures++; $display("FAIL random[%0d] we=%b addr=%h: got %b/%h/%b want 1/%h/0", i, we, a, got, rd, err, exp_rdata); end
            checks++; if (len != dly) begin failures++; $display("FAIL random_en_len[%0d]: got %0d want %0d", i, len, dly); end
        end
    endtask

`ifdef MEMCTRL_TIMEOUT_EN
    task automatic test_timeout();
        logic got, err; logic [31:0] rd; int len, k, rise;
        do_access(1'b0, 32'h10, 32'h0, 100000, 0, got, err, rd, len);
        rise = en_rise_cyc;
        checks++; if (got !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b/%b want 1/1", got, err); end
        checks++; if (rd !== exp_rdata) begin failures++; $display("FAIL timeout_rdata: got %h want %h", rd, exp_rdata); end
        if (got) begin
            checks++; if (resp_cyc_q[$] - rise != 64) begin failures++; $display("FAIL timeout_latency: got %0d want 64", resp_cyc_q[$] - rise); end
        end
        k = 0;
        while (!req_ready && k < 10) begin tick(); k++; end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL timeout_idle: got %b want 1", req_ready); end
        fin_delay = 4;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
`ifdef MEMCTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
